ad_scan_fifo: RTL and testbench

Parametrised multi-channel AD polling controller with a built-in byte FIFO. It drives an analog-mux channel address, waits a programmable settle time, and captures the AD sample. Samples are written into an on-chip FIFO, and each scan pass ends with a 0x0D 0x0A terminator. It sits between the mux/ADC front end and the UART/host readout logic. Compared with the fixed 32-channel block, it adds a channel mask, multi-pass and continuous modes, stop, overflow detection and a native FIFO with no vendor IP.

---
 rtl/ad_scan_fifo.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_ad_scan_fifo.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_scan_fifo.sv
// ad_scan_fifo
// Multi-channel AD polling controller with an on-chip byte FIFO.
// The FSM steps an analog-mux address over the enabled channels, waits a
// programmable settle time on each one and captures the AD sample into the
// FIFO. Every scan pass is closed with a CR/LF terminator. Masked channels
// cost one SEEK cycle each. The controller supports multi-pass, continuous
// and stop-terminated operation. The FIFO is a plain circular buffer with
// overflow detection.

module ad_scan_fifo #(
  parameter int DW      = 8,
  parameter int CH_NUM  = 32,
  parameter int ADDR_W  = 6,
  parameter int SETTLE  = 500000,
  parameter int FIFO_AW = 12
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  input  logic                mode,
  input  logic [7:0]          passes,
  input  logic [CH_NUM-1:0]   ch_mask,
  input  logic [DW-1:0]       ad_data,
  output logic [ADDR_W-1:0]   addr,
  output logic                busy,
  output logic                overflow,
  input  logic                rd_en,
  output logic [DW-1:0]       rd_data,
  output logic                empty,
  output logic                full,
  output logic [FIFO_AW:0]    usedw
);

  // Terminator words, zero-extended to the FIFO word width.
  localparam logic [DW-1:0]     CR_WORD     = DW'(8'h0D);
  localparam logic [DW-1:0]     LF_WORD     = DW'(8'h0A);
  localparam logic [ADDR_W-1:0] LAST_CH     = ADDR_W'(CH_NUM - 1);
  localparam logic [31:0]       SETTLE_LAST = 32'(SETTLE - 1);
  localparam logic [FIFO_AW:0]  FIFO_DEPTH  = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]  USEDW_ONE   = {{FIFO_AW{1'b0}}, 1'b1};
  localparam int                MEM_WORDS   = 2 ** FIFO_AW;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEEK    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_SAMPLE  = 3'd3,
    ST_TERM_CR = 3'd4,
    ST_TERM_LF = 3'd5
  } state_t;

  // ---------------------------------------------------------------------
  // Scan controller state
  // ---------------------------------------------------------------------
  state_t              state_r;
  state_t              state_nxt_s;
  logic                mode_r;
  logic [7:0]          passes_r;
  logic [CH_NUM-1:0]   mask_r;
  logic [7:0]          pass_cnt_r;
  logic [31:0]         settle_cnt_r;
  logic                stop_pend_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                busy_r;
  logic                overflow_r;

  // Control strobes produced by the next-state logic.
  logic                start_ok_s;
  logic                addr_inc_s;
  logic                addr_clr_s;
  logic                cnt_clr_s;
  logic                cnt_inc_s;
  logic                pass_inc_s;
  logic                wr_en_s;
  logic [DW-1:0]       wr_data_s;

  // Decoded conditions.
  logic [CH_NUM-1:0]   mask_sh_s;
  logic                mask_bit_s;
  logic                last_ch_s;
  logic                settle_done_s;
  logic                stop_pend_s;
  logic                pass_last_s;

  // ---------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------
  logic [DW-1:0]       mem_r [MEM_WORDS];
  logic [FIFO_AW-1:0]  wr_ptr_r;
  logic [FIFO_AW-1:0]  rd_ptr_r;
  logic [FIFO_AW:0]    usedw_r;
  logic [FIFO_AW:0]    usedw_nxt_s;
  logic                empty_r;
  logic                full_r;
  logic [DW-1:0]       rd_data_r;
  logic                wr_ok_s;
  logic                rd_ok_s;

  // Shifting the mask keeps the bit select in range for any ADDR_W.
  assign mask_sh_s     = mask_r >> addr_r;
  assign mask_bit_s    = mask_sh_s[0];
  assign last_ch_s     = (addr_r == LAST_CH);
  assign settle_done_s = (settle_cnt_r == SETTLE_LAST);
  // A stop arriving in the TERM_LF cycle itself still ends this pass.
  assign stop_pend_s   = stop_pend_r | stop;
  // Nine-bit compare so pass_cnt+1 cannot wrap before it reaches passes.
  assign pass_last_s   = (({1'b0, pass_cnt_r} + 9'd1) >= {1'b0, passes_r});

  // Next-state and control-strobe decode for the scan FSM.
  always_comb begin
    state_nxt_s = state_r;
    start_ok_s  = 1'b0;
    addr_inc_s  = 1'b0;
    addr_clr_s  = 1'b0;
    cnt_clr_s   = 1'b0;
    cnt_inc_s   = 1'b0;
    pass_inc_s  = 1'b0;
    wr_en_s     = 1'b0;
    wr_data_s   = {DW{1'b0}};
    case (state_r)
      ST_IDLE: begin
        // An all-zero mask would produce an endless empty scan; ignore it.
        if (start && (ch_mask != {CH_NUM{1'b0}})) begin
          start_ok_s  = 1'b1;
          state_nxt_s = ST_SEEK;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEEK: begin
        if (mask_bit_s) begin
          cnt_clr_s   = 1'b1;
          state_nxt_s = ST_SETTLE;
        end else if (last_ch_s) begin
          state_nxt_s = ST_TERM_CR;
        end else begin
          addr_inc_s  = 1'b1;
          state_nxt_s = ST_SEEK;
        end
      end
      ST_SETTLE: begin
        if (settle_done_s) begin
          state_nxt_s = ST_SAMPLE;
        end else begin
          cnt_inc_s   = 1'b1;
          state_nxt_s = ST_SETTLE;
        end
      end
      ST_SAMPLE: begin
        wr_en_s   = 1'b1;
        wr_data_s = ad_data;
        if (last_ch_s) begin
          state_nxt_s = ST_TERM_CR;
        end else begin
          addr_inc_s  = 1'b1;
          state_nxt_s = ST_SEEK;
        end
      end
      ST_TERM_CR: begin
        wr_en_s     = 1'b1;
        wr_data_s   = CR_WORD;
        state_nxt_s = ST_TERM_LF;
      end
      ST_TERM_LF: begin
        wr_en_s    = 1'b1;
        wr_data_s  = LF_WORD;
        pass_inc_s = 1'b1;
        if (stop_pend_s || (!mode_r && pass_last_s)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          addr_clr_s  = 1'b1;
          state_nxt_s = ST_SEEK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Scan configuration latched on an accepted start, plus pass bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_r      <= 1'b0;
      passes_r    <= 8'd1;
      mask_r      <= {CH_NUM{1'b0}};
      pass_cnt_r  <= 8'd0;
      stop_pend_r <= 1'b0;
    end else if (start_ok_s) begin
      mode_r      <= mode;
      passes_r    <= (passes == 8'd0) ? 8'd1 : passes;
      mask_r      <= ch_mask;
      pass_cnt_r  <= 8'd0;
      stop_pend_r <= 1'b0;
    end else begin
      if (pass_inc_s) begin
        pass_cnt_r <= pass_cnt_r + 8'd1;
      end
      if (stop && (state_r != ST_IDLE)) begin
        stop_pend_r <= 1'b1;
      end
    end
  end

  // Mux address: moves only when leaving SEEK, SAMPLE or TERM_LF.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_r <= {ADDR_W{1'b0}};
    end else if (start_ok_s || addr_clr_s) begin
      addr_r <= {ADDR_W{1'b0}};
    end else if (addr_inc_s) begin
      addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  // Settle timer, restarted on every entry into SETTLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      settle_cnt_r <= 32'd0;
    end else if (cnt_clr_s) begin
      settle_cnt_r <= 32'd0;
    end else if (cnt_inc_s) begin
      settle_cnt_r <= settle_cnt_r + 32'd1;
    end
  end

  // Registered busy and sticky overflow status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != ST_IDLE);
      if (start_ok_s) begin
        overflow_r <= 1'b0;
      end else if (wr_en_s && full_r) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------
  // A full FIFO drops the write even if a read frees a slot this cycle.
  assign wr_ok_s = wr_en_s & ~full_r;
  assign rd_ok_s = rd_en & ~empty_r;

  // Occupancy after this cycle's accepted read and write.
  always_comb begin
    usedw_nxt_s = usedw_r;
    case ({wr_ok_s, rd_ok_s})
      2'b10:   usedw_nxt_s = usedw_r + USEDW_ONE;
      2'b01:   usedw_nxt_s = usedw_r - USEDW_ONE;
      default: usedw_nxt_s = usedw_r;
    endcase
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data_s;
    end
  end

  // Pointers, registered flags and registered read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r  <= {FIFO_AW{1'b0}};
      rd_ptr_r  <= {FIFO_AW{1'b0}};
      usedw_r   <= {(FIFO_AW+1){1'b0}};
      empty_r   <= 1'b1;
      full_r    <= 1'b0;
      rd_data_r <= {DW{1'b0}};
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{(FIFO_AW-1){1'b0}}, 1'b1};
      end
      if (rd_ok_s) begin
        rd_ptr_r  <= rd_ptr_r + {{(FIFO_AW-1){1'b0}}, 1'b1};
        rd_data_r <= mem_r[rd_ptr_r];
      end
      usedw_r <= usedw_nxt_s;
      empty_r <= (usedw_nxt_s == {(FIFO_AW+1){1'b0}});
      full_r  <= (usedw_nxt_s == FIFO_DEPTH);
    end
  end

  assign addr     = addr_r;
  assign busy     = busy_r;
  assign overflow = overflow_r;
  assign rd_data  = rd_data_r;
  assign empty    = empty_r;
  assign full     = full_r;
  assign usedw    = usedw_r;

endmodule

// File: tb/tb_ad_scan_fifo.sv
// Testbench for ad_scan_fifo: small configuration (4 channels, settle 3,
// 8-word FIFO). The expected byte stream of each scan is pushed when the
// scan is started; a monitor pops it as read data emerges. Pass timing
// comes from the per-channel cost formula, and address dwell comes from
// the channel mask.

module tb_ad_scan_fifo;

  localparam int DW = 8, CH = 4, AW = 3, ST = 3, FAW = 3, DEPTH = 8;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           start, stop, mode, rd_en;
  logic [7:0]     passes;
  logic [CH-1:0]  ch_mask;
  logic [DW-1:0]  ad_data;
  logic [AW-1:0]  addr;
  logic           busy, overflow, empty, full;
  logic [DW-1:0]  rd_data;
  logic [FAW:0]   usedw;

  logic [7:0]     ad_tab [0:7];
  logic [7:0]     exp_q [$];
  logic [7:0]     cur_mask;
  logic [7:0]     last_rd;
  int             n_cmp = 0;
  int             n_fail = 0;
  int             rd_mode = 0;
  bit             chk_addr = 1'b1;
  longint         busy_total = 0;

  ad_scan_fifo #(.DW(DW), .CH_NUM(CH), .ADDR_W(AW), .SETTLE(ST), .FIFO_AW(FAW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .mode(mode),
    .passes(passes), .ch_mask(ch_mask), .ad_data(ad_data), .addr(addr),
    .busy(busy), .overflow(overflow), .rd_en(rd_en), .rd_data(rd_data),
    .empty(empty), .full(full), .usedw(usedw)
  );

  // The analog front end: the sample depends only on the addressed channel.
  assign ad_data = ad_tab[addr];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reader: 0 = idle, 1 = random (forced when filling up), 2 = always.
  initial begin
    rd_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rd_mode)
        1:       rd_en = (usedw >= 5) || ($urandom_range(3) != 0);
        2:       rd_en = 1'b1;
        default: rd_en = 1'b0;
      endcase
    end
  end

  // Monitor: read data, busy cycle count and per-address dwell.
  bit             acc_pend = 1'b0;
  bit             prev_busy = 1'b0;
  logic [AW-1:0]  prev_addr = '0;
  int             run = 0;
  always @(negedge clk) begin
    if (acc_pend) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_read: got 0x%0h expected none", rd_data);
      end else begin
        last_rd = exp_q.pop_front();
        check("rd_data", rd_data, last_rd);
      end
    end
    acc_pend = rd_en && !empty && reset_n;
    if (busy) busy_total++;
    if (busy && prev_busy && addr == prev_addr) begin
      run++;
    end else begin
      if (prev_busy && chk_addr) begin
        // Enabled channel: SEEK + settle + SAMPLE; masked: one SEEK.
        // The last channel also holds the address through CR and LF.
        int e;
        e = cur_mask[prev_addr] ? (ST + 2) : 1;
        if (prev_addr == AW'(CH - 1)) e += 2;
        check("addr_dwell", run, e);
      end
      run = busy ? 1 : 0;
    end
    prev_addr = addr;
    prev_busy = busy;
  end

  // Expected stream of a scan, truncated to lim words.
  task automatic push_scan(input logic [CH-1:0] m, input int np, input int lim);
    int n = 0;
    for (int p = 0; p < np; p++) begin
      for (int c = 0; c < CH; c++)
        if (m[c]) begin if (n < lim) exp_q.push_back(ad_tab[c]); n++; end
      if (n < lim) exp_q.push_back(8'h0D); n++;
      if (n < lim) exp_q.push_back(8'h0A); n++;
    end
  endtask

  function automatic int pass_len(input logic [CH-1:0] m);
    int k = $countones(m);
    return k * (ST + 2) + (CH - k) + 2;
  endfunction

  task automatic do_start(input logic [CH-1:0] m, input logic [7:0] ps, input logic md);
    cur_mask = {4'd0, m};
    ch_mask = m; passes = ps; mode = md; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 2000) begin tick(); n++; end
    if (n >= 2000) check({name, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin tick(); n++; end
    if (n >= 2000) check({name, "_drain_timeout"}, exp_q.size(), 64'd0);
    tick(); tick();
    check({name, "_empty"}, empty, 1'b1);
    check({name, "_usedw"}, usedw, 64'd0);
  endtask

  initial begin
    longint b0;
    int np, c;
    logic [CH-1:0] m;
    logic [7:0] ps;
    logic md;
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
    passes = 8'd0; ch_mask = '0; cur_mask = '0;
    for (int i = 0; i < 8; i++) ad_tab[i] = 8'h10 + 8'(i);
    tick(); tick();
    check("rst_busy", busy, 1'b0);
    check("rst_addr", addr, 64'd0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_rd_data", rd_data, 64'd0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_usedw", usedw, 64'd0);
    reset_n = 1'b1;
    tick();

    // 1: all four channels, one pass, no reads during the scan.
    push_scan(4'b1111, 1, 100);
    b0 = busy_total;
    do_start(4'b1111, 8'd1, 1'b0);
    wait_idle("t1");
    check("t1_pass_cycles", busy_total - b0, 64'd22);
    check("t1_usedw", usedw, 64'd6);
    rd_mode = 1;
    drain("t1");

    // 2: sparse mask, two passes, reading concurrently.
    push_scan(4'b0101, 2, 100);
    b0 = busy_total;
    do_start(4'b0101, 8'd2, 1'b0);
    wait_idle("t2");
    check("t2_cycles", busy_total - b0, 64'(2 * pass_len(4'b0101)));
    drain("t2");

    // 3: overflow with no reads; only the first DEPTH words survive.
    rd_mode = 0;
    push_scan(4'b1111, 2, DEPTH);
    do_start(4'b1111, 8'd2, 1'b0);
    wait_idle("t3");
    check("t3_full", full, 1'b1);
    check("t3_usedw", usedw, 64'(DEPTH));
    check("t3_overflow", overflow, 1'b1);
    rd_mode = 2;
    drain("t3");
    rd_mode = 0;
    check("t3_overflow_sticky", overflow, 1'b1);

    // 4: continuous mode, stop during settle of channel 1 in pass 3.
    rd_mode = 1;
    push_scan(4'b1111, 3, 100);
    b0 = busy_total;
    do_start(4'b1111, 8'd0, 1'b1);
    check("t4_overflow_cleared", overflow, 1'b0);
    for (int i = 0; i < 2 * 22 + 7; i++) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    wait_idle("t4");
    check("t4_cycles", busy_total - b0, 64'd66);
    drain("t4");

    // 5: reset mid-scan with five words queued, then a clean rescan.
    rd_mode = 0;
    chk_addr = 1'b0;
    do_start(4'b0011, 8'd2, 1'b0);
    c = 0;
    while (usedw != 5 && c < 200) begin tick(); c++; end
    check("t5_reach5", usedw, 64'd5);
    tick();
    reset_n = 1'b0;
    #1;
    check("t5_busy", busy, 1'b0);
    check("t5_addr", addr, 64'd0);
    check("t5_empty", empty, 1'b1);
    check("t5_usedw", usedw, 64'd0);
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    tick(); tick();
    chk_addr = 1'b1;
    rd_mode = 1;
    push_scan(4'b1111, 1, 100);
    do_start(4'b1111, 8'd1, 1'b0);
    wait_idle("t5b");
    drain("t5b");

    // 6: empty mask is ignored; reading an empty FIFO changes nothing.
    rd_mode = 0;
    b0 = busy_total;
    do_start(4'b0000, 8'd1, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    check("t6_no_busy", busy_total - b0, 64'd0);
    check("t6_usedw", usedw, 64'd0);
    rd_mode = 2;
    tick(); tick(); tick();
    rd_mode = 0;
    check("t6_rd_data_held", rd_data, last_rd);
    check("t6_usedw_after_rd", usedw, 64'd0);

    // Randomized scans against the stream/timing model.
    rd_mode = 1;
    for (int it = 0; it < 24; it++) begin
      m  = CH'($urandom_range(15));
      ps = 8'($urandom_range(3));
      md = ($urandom_range(2) == 0);
      for (int i = 0; i < 8; i++) ad_tab[i] = 8'($urandom);
      b0 = busy_total;
      if (m == '0) begin
        do_start(m, ps, md);
        for (int i = 0; i < 5; i++) tick();
        check("rnd_zero_mask", busy_total - b0, 64'd0);
      end else begin
        if (md) begin
          c  = $urandom_range(3 * pass_len(m) - 1);
          np = c / pass_len(m) + 1;
        end else begin
          c  = 0;
          np = (ps == 8'd0) ? 1 : int'(ps);
        end
        push_scan(m, np, 1000);
        do_start(m, ps, md);
        if (md) begin
          for (int i = 0; i < c; i++) tick();
          stop = 1'b1; tick(); stop = 1'b0;
        end
        wait_idle("rnd");
        check("rnd_cycles", busy_total - b0, 64'(np * pass_len(m)));
        drain("rnd");
        check("rnd_overflow", overflow, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "time limit reached");
  end

endmodule
